// File: rtl/isa_pkg.sv
// Shared ISA definitions: opcode constants and decode-sequencer state encoding.
// Imported by the instruction sequencer and, later, by the control unit.
package isa_pkg;

   localparam int unsigned OP_W = 5;

   typedef logic [OP_W-1:0] opcode_t;

   localparam opcode_t OP_NOP   = 5'b00000;
   localparam opcode_t OP_LDM   = 5'b10001;
   localparam opcode_t OP_CALL  = 5'b11000;
   localparam opcode_t OP_CALL2 = 5'b11001;
   localparam opcode_t OP_RET   = 5'b11010;
   localparam opcode_t OP_RET2  = 5'b11011;
   localparam opcode_t OP_RTI   = 5'b11100;
   localparam opcode_t OP_RTI2  = 5'b11101;
   localparam opcode_t OP_INT1  = 5'b11110;
   localparam opcode_t OP_INT2  = 5'b11111;

   typedef enum logic [2:0] {
      S_NORM   = 3'd0,
      S_CALL2  = 3'd1,
      S_RET2   = 3'd2,
      S_RTI2   = 3'd3,
      S_LDMIMM = 3'd4,
      S_INT2   = 3'd5
   } seq_state_t;

endpackage

// File: rtl/instr_sequencer.sv
// Decode-stage front end between the fetch buffer and the control unit.
// Expands CALL/RET/RTI into two opcodes, tags the LDM immediate word, injects
// the two-cycle interrupt sequence and turns stalls/flushes into bubbles.
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   fetch_opcode, fetch_valid  currently fetched word
//   stall, flush, int_req      hazard hold, branch discard, interrupt pulse
//   dec_opcode, make_bubble    registered opcode / bubble to control unit
//   imm_cycle, int_ack         registered LDM-immediate flag / interrupt ack
//   pc_hold                    combinational PC hold back to fetch
//   busy                       FSM is mid-sequence
module instr_sequencer
   import isa_pkg::*;
#(
   parameter int unsigned    OP_W   = 5,
   parameter logic [OP_W-1:0] NOP_OP = '0
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [OP_W-1:0] fetch_opcode,
   input  logic            fetch_valid,
   input  logic            stall,
   input  logic            flush,
   input  logic            int_req,
   output logic [OP_W-1:0] dec_opcode,
   output logic            make_bubble,
   output logic            imm_cycle,
   output logic            pc_hold,
   output logic            int_ack,
   output logic            busy
);

   seq_state_t      state, stateNext;
   logic            intPend, intClr;
   logic [OP_W-1:0] opNext;
   logic            bubbleNext, immNext, ackNext, pcHoldNext;
   logic            illegalOp;

   // Second-part and interrupt opcodes may only be generated internally.
   assign illegalOp = (fetch_opcode == OP_W'(OP_CALL2)) || (fetch_opcode == OP_W'(OP_RET2)) ||
                      (fetch_opcode == OP_W'(OP_RTI2))  || (fetch_opcode == OP_W'(OP_INT1)) ||
                      (fetch_opcode == OP_W'(OP_INT2));

   // Next-state and next-output decode.
   always_comb begin
      stateNext  = state;
      opNext     = NOP_OP;
      bubbleNext = 1'b1;
      immNext    = 1'b0;
      ackNext    = 1'b0;
      pcHoldNext = 1'b0;
      intClr     = 1'b0;
      if (stall) begin
         pcHoldNext = 1'b1;
      end else if (flush && (state == S_NORM || state == S_LDMIMM)) begin
         stateNext = S_NORM;
      end else begin
         case (state)
            S_NORM: begin
               if (intPend || int_req) begin
                  // Interrupt pre-empts the fetched word, which is replayed later.
                  opNext     = OP_W'(OP_INT1);
                  bubbleNext = 1'b0;
                  ackNext    = 1'b1;
                  pcHoldNext = 1'b1;
                  intClr     = 1'b1;
                  stateNext  = S_INT2;
               end else if (fetch_valid && !illegalOp) begin
                  opNext     = fetch_opcode;
                  bubbleNext = 1'b0;
                  if (fetch_opcode == OP_W'(OP_CALL)) begin
                     pcHoldNext = 1'b1;
                     stateNext  = S_CALL2;
                  end else if (fetch_opcode == OP_W'(OP_RET)) begin
                     pcHoldNext = 1'b1;
                     stateNext  = S_RET2;
                  end else if (fetch_opcode == OP_W'(OP_RTI)) begin
                     pcHoldNext = 1'b1;
                     stateNext  = S_RTI2;
                  end else if (fetch_opcode == OP_W'(OP_LDM)) begin
                     stateNext  = S_LDMIMM;
                  end
               end
            end
            S_CALL2, S_RET2, S_RTI2, S_INT2: begin
               bubbleNext = 1'b0;
               pcHoldNext = 1'b1;
               stateNext  = S_NORM;
               case (state)
                  S_CALL2: opNext = OP_W'(OP_CALL2);
                  S_RET2:  opNext = OP_W'(OP_RET2);
                  S_RTI2:  opNext = OP_W'(OP_RTI2);
                  default: opNext = OP_W'(OP_INT2);
               endcase
            end
            S_LDMIMM: begin
               if (fetch_valid) begin
                  bubbleNext = 1'b0;
                  immNext    = 1'b1;
                  stateNext  = S_NORM;
               end
            end
            default: stateNext = S_NORM;
         endcase
      end
   end

   assign pc_hold = rst_n & pcHoldNext;
   assign busy    = (state != S_NORM);

   // State, pending-interrupt and registered outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= S_NORM;
         intPend     <= 1'b0;
         dec_opcode  <= NOP_OP;
         make_bubble <= 1'b1;
         imm_cycle   <= 1'b0;
         int_ack     <= 1'b0;
      end else begin
         state       <= stateNext;
         // A new request arriving while a pending one is consumed survives.
         intPend     <= intClr ? (intPend & int_req) : (intPend | int_req);
         dec_opcode  <= opNext;
         make_bubble <= bubbleNext;
         imm_cycle   <= immNext;
         int_ack     <= ackNext;
      end
   end

endmodule

// File: tb/tb_instr_sequencer.sv
module tb_instr_sequencer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [4:0] fetch_opcode;
   logic       fetch_valid, stall, flush, int_req;
   logic [4:0] dec_opcode;
   logic       make_bubble, imm_cycle, pc_hold, int_ack, busy;

   instr_sequencer dut (
      .clk(clk), .rst_n(rst_n), .fetch_opcode(fetch_opcode), .fetch_valid(fetch_valid),
      .stall(stall), .flush(flush), .int_req(int_req), .dec_opcode(dec_opcode),
      .make_bubble(make_bubble), .imm_cycle(imm_cycle), .pc_hold(pc_hold),
      .int_ack(int_ack), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      int       cyc;
      int       step;
      logic [8:0] val;
   } exp_t;

   exp_t combQ[$];
   exp_t regQ[$];
   int   cyc = 0;
   int   stepNo = 0;
   int   checks = 0;
   int   failures = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: compare every expectation due in the current cycle.
   always @(negedge clk) begin
      while (combQ.size() > 0 && combQ[0].cyc == cyc) begin
         exp_t e;
         e = combQ.pop_front();
         checks++;
         if (pc_hold !== e.val[0]) begin
            failures++;
            $display("FAIL pc_hold step=%0d got=%b exp=%b", e.step, pc_hold, e.val[0]);
         end
      end
      while (regQ.size() > 0 && regQ[0].cyc == cyc) begin
         exp_t e;
         logic [8:0] got;
         e = regQ.pop_front();
         got = {dec_opcode, make_bubble, imm_cycle, int_ack, busy};
         checks++;
         if (got !== e.val) begin
            failures++;
            $display("FAIL outputs step=%0d got{op,bub,imm,ack,busy}=%b_%b%b%b%b exp=%b_%b%b%b%b",
                     e.step, got[8:4], got[3], got[2], got[1], got[0],
                     e.val[8:4], e.val[3], e.val[2], e.val[1], e.val[0]);
         end
      end
   end

   // Apply one cycle of stimulus and queue its expected responses.
   task automatic step(input logic r, input logic [4:0] op, input logic fv, input logic st,
                       input logic fl, input logic ir, input logic expPc,
                       input logic [4:0] expOp, input logic expBub, input logic expImm,
                       input logic expAck, input logic expBusy);
      exp_t e;
      @(posedge clk);
      #1;
      rst_n = r; fetch_opcode = op; fetch_valid = fv; stall = st; flush = fl; int_req = ir;
      stepNo++;
      e.step = stepNo;
      e.cyc = cyc;     e.val = {8'd0, expPc};                           combQ.push_back(e);
      e.cyc = cyc + 1; e.val = {expOp, expBub, expImm, expAck, expBusy}; regQ.push_back(e);
   endtask

   initial begin
      rst_n = 1'b0; fetch_opcode = 5'b11000; fetch_valid = 1'b1;
      stall = 1'b0; flush = 1'b0; int_req = 1'b0;
      //    rst op        fv st fl ir  pc  expOp     bub imm ack busy
      // reset with CALL presented
      step(0, 5'b11000, 1, 0, 0, 0,  0, 5'b00000, 1, 0, 0, 0);
      step(0, 5'b11000, 1, 0, 0, 0,  0, 5'b00000, 1, 0, 0, 0);
      // CALL then RET expansion
      step(1, 5'b11000, 1, 0, 0, 0,  1, 5'b11000, 0, 0, 0, 1);
      step(1, 5'b00101, 1, 0, 0, 0,  1, 5'b11001, 0, 0, 0, 0);
      step(1, 5'b11010, 1, 0, 0, 0,  1, 5'b11010, 0, 0, 0, 1);
      step(1, 5'b11010, 1, 0, 0, 0,  1, 5'b11011, 0, 0, 0, 0);
      step(1, 5'b00011, 1, 0, 0, 0,  0, 5'b00011, 0, 0, 0, 0);
      // interrupt colliding with RET
      step(1, 5'b11010, 1, 0, 0, 1,  1, 5'b11110, 0, 0, 1, 1);
      step(1, 5'b11010, 1, 0, 0, 0,  1, 5'b11111, 0, 0, 0, 0);
      step(1, 5'b11010, 1, 0, 0, 0,  1, 5'b11010, 0, 0, 0, 1);
      step(1, 5'b11010, 1, 0, 0, 0,  1, 5'b11011, 0, 0, 0, 0);
      // stall twice mid-CALL, flush ignored in second part
      step(1, 5'b11000, 1, 0, 0, 0,  1, 5'b11000, 0, 0, 0, 1);
      step(1, 5'b00001, 1, 1, 0, 0,  1, 5'b00000, 1, 0, 0, 1);
      step(1, 5'b00001, 1, 1, 0, 0,  1, 5'b00000, 1, 0, 0, 1);
      step(1, 5'b00001, 1, 0, 1, 0,  1, 5'b11001, 0, 0, 0, 0);
      // LDM with immediate, then LDM with idle fetch and flush
      step(1, 5'b10001, 1, 0, 0, 0,  0, 5'b10001, 0, 0, 0, 1);
      step(1, 5'b00111, 1, 0, 0, 0,  0, 5'b00000, 0, 1, 0, 0);
      step(1, 5'b10001, 1, 0, 0, 0,  0, 5'b10001, 0, 0, 0, 1);
      step(1, 5'b00111, 0, 0, 0, 0,  0, 5'b00000, 1, 0, 0, 1);
      step(1, 5'b00111, 1, 0, 1, 0,  0, 5'b00000, 1, 0, 0, 0);
      // interrupt deferred during RTI second part
      step(1, 5'b11100, 1, 0, 0, 0,  1, 5'b11100, 0, 0, 0, 1);
      step(1, 5'b00010, 1, 0, 0, 1,  1, 5'b11101, 0, 0, 0, 0);
      step(1, 5'b00010, 1, 0, 0, 0,  1, 5'b11110, 0, 0, 1, 1);
      step(1, 5'b00010, 1, 0, 0, 0,  1, 5'b11111, 0, 0, 0, 0);
      step(1, 5'b00010, 1, 0, 0, 0,  0, 5'b00010, 0, 0, 0, 0);
      // two pulses before service merge into one ack
      step(1, 5'b11000, 1, 0, 0, 0,  1, 5'b11000, 0, 0, 0, 1);
      step(1, 5'b00100, 1, 1, 0, 1,  1, 5'b00000, 1, 0, 0, 1);
      step(1, 5'b00100, 1, 0, 0, 1,  1, 5'b11001, 0, 0, 0, 0);
      step(1, 5'b00100, 1, 0, 0, 0,  1, 5'b11110, 0, 0, 1, 1);
      step(1, 5'b00100, 1, 0, 0, 0,  1, 5'b11111, 0, 0, 0, 0);
      step(1, 5'b00100, 1, 0, 0, 0,  0, 5'b00100, 0, 0, 0, 0);
      // illegal fetched opcodes, flush in normal state
      step(1, 5'b11111, 1, 0, 0, 0,  0, 5'b00000, 1, 0, 0, 0);
      step(1, 5'b11001, 1, 0, 0, 0,  0, 5'b00000, 1, 0, 0, 0);
      step(1, 5'b00101, 1, 0, 1, 0,  0, 5'b00000, 1, 0, 0, 0);
      // reset abandons a CALL sequence
      step(1, 5'b11000, 1, 0, 0, 0,  1, 5'b11000, 0, 0, 0, 1);
      step(0, 5'b00110, 1, 0, 0, 0,  0, 5'b00000, 1, 0, 0, 0);
      step(1, 5'b00110, 1, 0, 0, 0,  0, 5'b00110, 0, 0, 0, 0);
      step(1, 5'b00110, 0, 0, 0, 0,  0, 5'b00000, 1, 0, 0, 0);
      // drain outstanding expectations within a bounded number of cycles
      for (int i = 0; i < 4 && (regQ.size() > 0 || combQ.size() > 0); i++) @(posedge clk);
      @(posedge clk);
      if (regQ.size() > 0 || combQ.size() > 0) begin
         failures++;
         $display("FAIL drain pending=%0d required=0", regQ.size() + combQ.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Decode-stage front end that sits between the fetch buffer and the control unit.
- Expands two-part instructions (CALL, RET, RTI) into their first and second opcodes, and marks the immediate word of LDM.
- Injects the two-cycle interrupt sequence (11110, 11111) and turns stalls and flushes into bubbles.
- Drives the control unit's opcode and bubble inputs, plus the PC hold signal back to fetch.

Parameters:
- OP_W, 5, opcode width.
- NOP_OP, 5'b00000, opcode driven on bubble and immediate cycles.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous reset, active-low.
- fetch_opcode  in  OP_W  opcode field of the currently fetched word.
- fetch_valid  in  1  fetched word is valid.
- stall  in  1  load-use hazard; decode must hold.
- flush  in  1  taken branch/jump resolved downstream; discard the fetched word.
- int_req  in  1  external interrupt, one-cycle pulse.
- dec_opcode  out  OP_W  opcode to the control unit (registered).
- make_bubble  out  1  bubble request to the control unit (registered).
- imm_cycle  out  1  current word is the LDM immediate; the control unit must not decode it.
- pc_hold  out  1  fetch must not advance the PC this cycle (combinational from state).
- int_ack  out  1  one-cycle pulse when 11110 is issued.
- busy  out  1  FSM is not in S_NORM.

Behaviour:
- Clock and reset: one clock domain (clk); synchronous, active-low reset (rst_n).
- Reset values:
  - state = S_NORM, dec_opcode = NOP_OP, make_bubble = 1, imm_cycle = 0, int_ack = 0, int_pend = 0, pc_hold = 0.
  - Reset mid-sequence abandons the sequence; no second part is issued.
- Latency: dec_opcode, make_bubble, imm_cycle and int_ack are registered, one cycle after the fetched word is sampled.
- int_pend:
  - Set by int_req.
  - Cleared in the cycle 11110 is issued.
  - int_req arriving while int_pend=1 is merged (a single interrupt is taken).
  - A simultaneous set and clear leaves int_pend=1.
- States: S_NORM, S_CALL2, S_RET2, S_RTI2, S_LDMIMM, S_INT2.
- Priority in every state: stall > flush > state action.
- stall:
  - State and int_pend are held.
  - make_bubble <= 1, dec_opcode <= NOP_OP.
  - pc_hold = 1.
- flush:
  - In S_NORM or S_LDMIMM: make_bubble <= 1, next state S_NORM, pc_hold = 0.
  - In S_CALL2/S_RET2/S_RTI2/S_INT2: flush is ignored, because the sequence is atomic.
- S_NORM with (int_pend | int_req) and no stall/flush:
  - dec_opcode <= 11110, int_ack <= 1.
  - pc_hold = 1, so the fetched word is replayed later.
  - Next state S_INT2.
  - The interrupt is taken before the fetched word, including when that word is CALL/RET/RTI/LDM.
- S_NORM with fetch_valid=0: bubble, remain in S_NORM.
- S_NORM otherwise: dec_opcode <= fetch_opcode, make_bubble <= 0. Then by opcode:
  - 11000 (CALL): pc_hold = 1, next S_CALL2.
  - 11010 (RET): pc_hold = 1, next S_RET2.
  - 11100 (RTI): pc_hold = 1, next S_RTI2.
  - 10001 (LDM): next S_LDMIMM.
  - Any other opcode: stay in S_NORM.
- Second-part states (pc_hold = 1, next S_NORM):
  - S_CALL2: dec_opcode <= 11001.
  - S_RET2: dec_opcode <= 11011.
  - S_RTI2: dec_opcode <= 11101.
  - S_INT2: dec_opcode <= 11111.
  - An interrupt during any of these stays pending and is taken at the next S_NORM cycle.
- S_LDMIMM:
  - If fetch_valid: dec_opcode <= NOP_OP, imm_cycle <= 1, make_bubble <= 0, next S_NORM.
  - If !fetch_valid: bubble, stay in S_LDMIMM.
  - Interrupts are deferred.
- Opcodes 11001, 11011, 11101, 11110 and 11111 arriving from fetch in S_NORM are illegal: convert to a bubble and stay in S_NORM.
- busy = (state != S_NORM).

Decomposition:
- Shared package isa_pkg holds:
  - opcode constants OP_NOP, OP_LDM, OP_CALL, OP_CALL2, OP_RET, OP_RET2, OP_RTI, OP_RTI2, OP_INT1, OP_INT2;
  - seq_state_t enum.
- The control unit will import the same package later.
- No sub-module: a single FSM plus the int_pend flop.

Test Plan:
- Reset: rst_n=0 for 2 cycles with fetch_opcode=11000 -> make_bubble=1, dec_opcode=00000, pc_hold=0, busy=0. Release reset -> next cycle dec_opcode=11000.
- CALL: fetch 11000 -> dec_opcode 11000 then 11001; pc_hold=1 for 2 cycles; busy=1 in cycle 2; RET (11010) likewise gives 11010, 11011.
- Interrupt collision: int_req pulse in the same cycle fetch presents 11010 -> dec_opcode 11110 (int_ack=1), then 11111, then 11010, 11011; pc_hold high for 4 consecutive cycles.
- Stall mid-CALL: stall=1 for 2 cycles in S_CALL2 -> 2 bubbles, state held; after release dec_opcode=11001; a flush in S_CALL2 is ignored.
- LDM: fetch 10001 then immediate word with opcode bits 00111 -> dec_opcode 10001, then 00000 with imm_cycle=1; flush in S_LDMIMM -> bubble, return to S_NORM, imm_cycle never asserted.
- Interrupt deferral: int_req during S_RTI2 -> 11101 issued first, then 11110 next cycle; two int_req pulses before service -> exactly one int_ack.
